// File: rtl/ovfl_mon_pkg.sv
// Shared constants for the ADC overflow monitor: register-map opcode and default
// window/threshold settings. Imported by ovfl_mon and ovfl_mon_chan.
package ovfl_mon_pkg;

  localparam int DEF_WIN_BITS = 16;
  localparam int DEF_THRESH   = 1;
  localparam int MAX_NCH      = 8;

  typedef enum logic [3:0] {
    REG_CTRL   = 4'h0,
    REG_THRESH = 4'h1,
    REG_STATUS = 4'h2,
    REG_PEAK   = 4'h3
  } reg_op_e;

  // Opcode the host register decoder turns into a thresh_wr strobe.
  localparam reg_op_e OP_THRESH_WR = REG_THRESH;

endpackage

// File: rtl/ovfl_mon_chan.sv
// One overflow channel: per-window count, threshold compare, sticky flag and,
// with OVFL_MON_PEAK_EN defined, the running peak window count.
module ovfl_mon_chan
  import ovfl_mon_pkg::*;
#(
  parameter int CW = DEF_WIN_BITS + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ovfl,
  input  logic          last,
  input  logic          clr,
  input  logic [CW-1:0] thr,
  output logic          pulse,
  output logic          sticky
`ifdef OVFL_MON_PEAK_EN
  ,
  output logic [CW-1:0] peak
`endif
);

  logic [CW-1:0] count;
  logic [CW-1:0] fin_cnt;
  logic          hit;

  // CW is one bit wider than the window index, so a full window of overflows fits.
  assign fin_cnt = count + CW'(ovfl);
  assign hit     = (thr != '0) && (fin_cnt >= thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= last & hit;
      count <= last ? '0 : fin_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        sticky <= 1'b0;
    else if (pulse) sticky <= 1'b1;
    else if (clr)   sticky <= 1'b0;
  end

`ifdef OVFL_MON_PEAK_EN
  logic [CW-1:0] peak_base;

  // A clear landing on the window end still records that window, measured from zero.
  assign peak_base = clr ? '0 : peak;

  always_ff @(posedge clk) begin
    if (rst)       peak <= '0;
    else if (last) peak <= (fin_cnt > peak_base) ? fin_cnt : peak_base;
    else if (clr)  peak <= '0;
  end
`endif

endmodule

// File: rtl/ovfl_mon.sv
// ADC overflow monitor top: shared window counter and double-buffered threshold,
// NCH generated channels. Define OVFL_MON_PEAK_EN to add the per-channel peak port.
module ovfl_mon
  import ovfl_mon_pkg::*;
#(
  parameter int NCH        = 1,
  parameter int WIN_BITS   = DEF_WIN_BITS,
  parameter int THRESH_RST = DEF_THRESH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NCH-1:0]              ovfl_in,
  input  logic                        thresh_wr,
  input  logic [WIN_BITS:0]           thresh,
  input  logic                        clr,
  output logic                        win_end,
  output logic [NCH-1:0]              ovfl_pulse,
  output logic [NCH-1:0]              ovfl_sticky
`ifdef OVFL_MON_PEAK_EN
  ,
  output logic [NCH*(WIN_BITS+1)-1:0] peak
`endif
);

  localparam int CW = WIN_BITS + 1;

  logic [WIN_BITS-1:0] win_cnt;
  logic                last;
  logic [CW-1:0]       thr_pend;
  logic [CW-1:0]       thr_act;

  assign last = &win_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      win_end <= 1'b0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      win_end <= last;
    end
  end

  // The active threshold only changes at a window boundary, after that window's compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_pend <= CW'(THRESH_RST);
      thr_act  <= CW'(THRESH_RST);
    end else begin
      if (thresh_wr) thr_pend <= thresh;
      if (last)      thr_act  <= thr_pend;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    ovfl_mon_chan #(
      .CW(CW)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .ovfl  (ovfl_in[i]),
      .last  (last),
      .clr   (clr),
      .thr   (thr_act),
      .pulse (ovfl_pulse[i]),
      .sticky(ovfl_sticky[i])
`ifdef OVFL_MON_PEAK_EN
      ,
      .peak  (peak[i*CW +: CW])
`endif
    );
  end

endmodule

// File: tb/tb_ovfl_mon.sv
// Self-checking bench for ovfl_mon (NCH=2, WIN_BITS=4): window vector table with a
// pulse scoreboard, plus sequences for clear, mid-window reset and peak tracking.
module tb_ovfl_mon;

  localparam int NCH      = 2;
  localparam int WIN_BITS = 4;
  localparam int WIN      = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ovfl_in = '0;
  logic       thresh_wr = 1'b0;
  logic [4:0] thresh = '0;
  logic       clr = 1'b0;
  logic       win_end;
  logic [1:0] ovfl_pulse;
  logic [1:0] ovfl_sticky;
`ifdef OVFL_MON_PEAK_EN
  logic [9:0] peak;
`endif

  ovfl_mon #(
    .NCH       (NCH),
    .WIN_BITS  (WIN_BITS),
    .THRESH_RST(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ovfl_in    (ovfl_in),
    .thresh_wr  (thresh_wr),
    .thresh     (thresh),
    .clr        (clr),
    .win_end    (win_end),
    .ovfl_pulse (ovfl_pulse),
    .ovfl_sticky(ovfl_sticky)
`ifdef OVFL_MON_PEAK_EN
    ,
    .peak       (peak)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n0;
    int         n1;
    int         wa_at;
    logic [4:0] wa_val;
    int         wb_at;
    logic [4:0] wb_val;
    logic [1:0] exp_pulse;
  } vec_t;

  vec_t       vecs[11];
  logic [1:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         since = 0;
  logic [1:0] sticky_model;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply_stimulus(input logic [1:0] o, input logic wr, input logic [4:0] tv,
                                input logic c);
    ovfl_in   = o;
    thresh_wr = wr;
    thresh    = tv;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k);
    logic [1:0] o;
    logic       wr;
    logic [4:0] tv;
    exp_q.push_back(vecs[k].exp_pulse);
    for (int c = 0; c < WIN; c++) begin
      o[0] = (c < vecs[k].n0);
      o[1] = (c < vecs[k].n1);
      wr   = (c == vecs[k].wa_at) || (c == vecs[k].wb_at);
      tv   = (c == vecs[k].wb_at) ? vecs[k].wb_val : vecs[k].wa_val;
      apply_stimulus(o, wr, tv, 1'b0);
    end
  endtask

  task automatic run_plain(input int n0, input int n1, input logic [1:0] exp);
    logic [1:0] o;
    exp_q.push_back(exp);
    for (int c = 0; c < WIN; c++) begin
      o[0] = (c < n0);
      o[1] = (c < n1);
      apply_stimulus(o, 1'b0, 5'd0, 1'b0);
    end
  endtask

  // Cycles since reset release; a window end is due every WIN cycles of it.
  always @(posedge clk) begin
    if (rst) since <= 0;
    else     since <= since + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_output("win_end timing", {31'd0, win_end}, {31'd0, (since > 0) && (since % WIN == 0)});
      if (win_end === 1'b1) begin
        if (exp_q.size() == 0) check_output("scoreboard underflow", 32'd1, 32'd0);
        else                   check_output("ovfl_pulse", {30'd0, ovfl_pulse}, {30'd0, exp_q.pop_front()});
      end else begin
        check_output("idle pulse", {30'd0, ovfl_pulse}, 32'd0);
      end
    end
  end

  initial begin
    // n0, n1, write A at/value, write B at/value, expected pulse at window end
    vecs[0]  = '{1,  0,  -1, 5'd0,  -1, 5'd0, 2'b01};
    vecs[1]  = '{5,  0,   7, 5'd5,  -1, 5'd0, 2'b01};
    vecs[2]  = '{4,  5,  -1, 5'd0,  -1, 5'd0, 2'b10};
    vecs[3]  = '{5,  3,  -1, 5'd0,  -1, 5'd0, 2'b01};
    vecs[4]  = '{16, 15,  3, 5'd16, -1, 5'd0, 2'b11};
    vecs[5]  = '{16, 15, 15, 5'd0,  -1, 5'd0, 2'b01};
    vecs[6]  = '{16, 16, -1, 5'd0,  -1, 5'd0, 2'b11};
    vecs[7]  = '{16, 16, -1, 5'd0,  -1, 5'd0, 2'b00};
    vecs[8]  = '{16, 16,  0, 5'd2,  10, 5'd3, 2'b00};
    vecs[9]  = '{2,  3,  -1, 5'd0,  -1, 5'd0, 2'b10};
    vecs[10] = '{3,  2,  -1, 5'd0,  -1, 5'd0, 2'b01};

    repeat (3) @(posedge clk);
    #1;
    check_output("reset win_end", {31'd0, win_end}, 32'd0);
    check_output("reset ovfl_pulse", {30'd0, ovfl_pulse}, 32'd0);
    check_output("reset ovfl_sticky", {30'd0, ovfl_sticky}, 32'd0);
`ifdef OVFL_MON_PEAK_EN
    check_output("reset peak", {22'd0, peak}, 32'd0);
`endif
    rst = 1'b0;

    sticky_model = 2'b00;
    for (int k = 0; k < 11; k++) begin
      run_vec(k);
      check_output("ovfl_sticky", {30'd0, ovfl_sticky}, {30'd0, sticky_model});
      sticky_model = sticky_model | vecs[k].exp_pulse;
    end

    // clr lands on the pulse of the last table window: ch0 re-sets, ch1 clears.
    exp_q.push_back(2'b00);
    apply_stimulus(2'b00, 1'b0, 5'd0, 1'b1);
    check_output("sticky set beats clr", {30'd0, ovfl_sticky}, 32'd1);
    apply_stimulus(2'b00, 1'b0, 5'd0, 1'b1);
    check_output("sticky clr", {30'd0, ovfl_sticky}, 32'd0);
    for (int c = 2; c < WIN; c++) apply_stimulus(2'b00, 1'b0, 5'd0, 1'b0);

    // Reset at sample 8 of a window holding 8 overflows per channel.
    for (int c = 0; c < 8; c++) apply_stimulus(2'b11, 1'b0, 5'd0, 1'b0);
    ovfl_in = 2'b00;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    check_output("mid-window reset pulse", {30'd0, ovfl_pulse}, 32'd0);
    check_output("mid-window reset win_end", {31'd0, win_end}, 32'd0);
    rst = 1'b0;
    run_plain(0, 0, 2'b00);
    run_plain(1, 0, 2'b01);

`ifdef OVFL_MON_PEAK_EN
    run_plain(3, 0, 2'b01);
    check_output("peak after 3", {22'd0, peak}, 32'd3);
    run_plain(7, 0, 2'b01);
    check_output("peak after 7", {22'd0, peak}, 32'd7);
    run_plain(2, 0, 2'b01);
    check_output("peak after 2", {22'd0, peak}, 32'd7);
    exp_q.push_back(2'b01);
    apply_stimulus(2'b00, 1'b0, 5'd0, 1'b1);
    check_output("peak clr", {22'd0, peak}, 32'd0);
    for (int c = 1; c < WIN; c++) apply_stimulus({1'b0, c <= 2}, 1'b0, 5'd0, 1'b0);
    check_output("peak after clr", {22'd0, peak}, 32'd2);
`endif

    @(negedge clk);
    #1;
    check_output("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
